// File: rtl/gpio_operand_rx_if.sv
// Operand handoff between the GPIO byte receiver and the float divider core.
// The receiver drives the operand pair and valid; the divider answers with ready.
interface gpio_operand_rx_if;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_valid;
    logic        op_ready;

    modport master (
        output op_a,
        output op_b,
        output op_valid,
        input  op_ready
    );

    modport slave (
        input  op_a,
        input  op_b,
        input  op_valid,
        output op_ready
    );
endinterface

// File: rtl/gpio_operand_rx.sv
// Host-side byte receiver for the float divider.
// Bytes arrive on mprj_io pins qualified by a four-phase strobe/ack handshake,
// are assembled little-endian into dividend A (bytes 0-3) and divisor B
// (bytes 4-7), and are presented to the divider over valid/ready.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// WAIT_HI    | idle, waiting for the host strobe to rise; timeout runs here
// WAIT_LO    | byte captured and acked, waiting for the strobe to fall
// PRESENT    | full operand pair offered to the divider; host is stalled
module gpio_operand_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clock,
    input  logic                      resetb,
    input  logic [7:0]                io_data,
    input  logic                      io_strb,
    output logic                      io_ack,
    gpio_operand_rx_if.master         op_if,
    output logic [2:0]                byte_idx,
    output logic                      err_timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WAIT_HI = 2'd0,
        ST_WAIT_LO = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    // Synchronizer chains for the asynchronous host pins.
    logic [SYNC_STAGES-1:0] r_strb_sync;
    logic [7:0]             r_data_sync [SYNC_STAGES];
    logic                   w_s_strb;
    logic [7:0]             w_s_data;

    // Control registers and their next-state values.
    state_t                 r_state;
    state_t                 w_state;
    logic                   r_ack;
    logic                   w_ack;
    logic                   r_valid;
    logic                   w_valid;
    logic [2:0]             r_byte_idx;
    logic [2:0]             w_byte_idx;
    logic                   r_full;
    logic                   w_full;
    logic                   r_err;
    logic                   w_err;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt;
    logic                   w_capture;

    // Operand assembly registers.
    logic [31:0]            r_op_a;
    logic [31:0]            r_op_b;

    assign w_s_strb = r_strb_sync[SYNC_STAGES-1];
    assign w_s_data = r_data_sync[SYNC_STAGES-1];

    // Shift the host strobe and data through the synchronizer stages.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_strb_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_data_sync[i] <= 8'h00;
            end
        end else begin
            r_strb_sync[0]    <= io_strb;
            r_data_sync[0]    <= io_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_strb_sync[i] <= r_strb_sync[i-1];
                r_data_sync[i] <= r_data_sync[i-1];
            end
        end
    end

    // State and control register update.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state    <= ST_WAIT_HI;
            r_ack      <= 1'b0;
            r_valid    <= 1'b0;
            r_byte_idx <= 3'd0;
            r_full     <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state;
            r_ack      <= w_ack;
            r_valid    <= w_valid;
            r_byte_idx <= w_byte_idx;
            r_full     <= w_full;
            r_err      <= w_err;
            r_cnt      <= w_cnt;
        end
    end

    // Next-state, handshake and idle-timeout decisions.
    always_comb begin
        w_state    = r_state;
        w_ack      = r_ack;
        w_valid    = r_valid;
        w_byte_idx = r_byte_idx;
        w_full     = r_full;
        w_err      = r_err;
        w_cnt      = '0;
        w_capture  = 1'b0;

        case (r_state)
            ST_WAIT_HI: begin
                if (w_s_strb) begin
                    // A strobe beats a coincident timeout: the byte is kept.
                    w_capture = 1'b1;
                    w_ack     = 1'b1;
                    w_err     = 1'b0;
                    w_state   = ST_WAIT_LO;
                    if (r_byte_idx == 3'd7) begin
                        w_byte_idx = 3'd0;
                        w_full     = 1'b1;
                    end else begin
                        w_byte_idx = r_byte_idx + 3'd1;
                    end
                end else if (r_byte_idx != 3'd0) begin
                    if (r_cnt == CNT_TC) begin
                        w_byte_idx = 3'd0;
                        w_err      = 1'b1;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
            end

            ST_WAIT_LO: begin
                if (!w_s_strb) begin
                    w_ack = 1'b0;
                    if (r_full) begin
                        w_full  = 1'b0;
                        w_valid = 1'b1;
                        w_state = ST_PRESENT;
                    end else begin
                        w_state = ST_WAIT_HI;
                    end
                end
            end

            ST_PRESENT: begin
                // Strobes are left unacknowledged here so the host stalls.
                if (r_valid && op_if.op_ready) begin
                    w_valid = 1'b0;
                    w_state = ST_WAIT_HI;
                end
            end

            default: begin
                w_state = ST_WAIT_HI;
            end
        endcase
    end

    // Write the synchronized byte into the lane chosen by the byte index.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_op_a <= 32'h0000_0000;
            r_op_b <= 32'h0000_0000;
        end else if (w_capture) begin
            if (r_byte_idx[2]) begin
                r_op_b[8*r_byte_idx[1:0] +: 8] <= w_s_data;
            end else begin
                r_op_a[8*r_byte_idx[1:0] +: 8] <= w_s_data;
            end
        end
    end

    assign io_ack         = r_ack;
    assign byte_idx       = r_byte_idx;
    assign err_timeout    = r_err;
    assign op_if.op_a     = r_op_a;
    assign op_if.op_b     = r_op_b;
    assign op_if.op_valid = r_valid;

endmodule

// File: doc/gpio_operand_rx.md
Name: gpio_operand_rx

Overview:
- Host-side byte receiver for the user-project float divider. The project already drives results out on mprj_io[7:0]; this block is the inbound path.
- An external host presents bytes on eight mprj_io input pins. Each byte is qualified by an asynchronous strobe pin using a four-phase strobe/ack handshake.
- The block assembles two 32-bit IEEE-754 operands (dividend A, divisor B) and hands them to the divider core over a valid/ready interface.
- It sits in user_project_wrapper between the io_in pins and the divider.

Parameters:
- SYNC_STAGES, 2, synchronizer depth applied to io_strb and io_data (minimum 2).
- TIMEOUT_CYCLES, 4096, idle cycles allowed mid-frame before a partial frame is discarded (minimum 2).

Ports:
- clock  input  1  system clock (wb_clk_i domain).
- resetb  input  1  asynchronous, active-low reset.
- io_data  input  8  byte from host pins; asynchronous to clock.
- io_strb  input  1  host strobe; asynchronous to clock; high = byte valid.
- io_ack  output  1  acknowledge to host pin.
- op_a  output  32  assembled dividend.
- op_b  output  32  assembled divisor.
- op_valid  output  1  operand pair valid.
- op_ready  input  1  divider accepts the pair.
- byte_idx  output  3  number of bytes received in the current frame (0..7).
- err_timeout  output  1  sticky flag: a partial frame was discarded.

Behaviour:
- Reset (async assert, synchronous-release usage by integrator): state=WAIT_HI, io_ack=0, op_valid=0, op_a=0, op_b=0, byte_idx=0, err_timeout=0, timeout counter=0, all synchronizer flops=0.
- Synchronization: io_strb and io_data each pass through SYNC_STAGES flops; s_strb and s_data are the last-stage outputs.
  - Host contract: io_data stays stable from before the io_strb rise until io_ack is seen high.
- Frame format: 8 bytes, little-endian.
  - Bytes 0-3 go to op_a[7:0], [15:8], [23:16], [31:24].
  - Bytes 4-7 go to op_b in the same order.
- State WAIT_HI:
  - On the edge where s_strb=1: write s_data into the byte lane selected by byte_idx; io_ack<=1; timeout counter<=0; err_timeout<=0; go to WAIT_LO.
  - Then if byte_idx==7: byte_idx<=0 and set internal full=1. Otherwise byte_idx<=byte_idx+1.
- State WAIT_LO:
  - io_ack holds 1. On the edge where s_strb=0: io_ack<=0.
  - If full: full<=0, op_valid<=1, go to PRESENT. Otherwise go to WAIT_HI.
  - No timeout in this state.
- State PRESENT:
  - op_valid=1; op_a and op_b are held stable.
  - A host strobe is not acknowledged (io_ack stays 0), so the host stalls; this is the backpressure mechanism.
  - On the edge where op_valid && op_ready: op_valid<=0, go to WAIT_HI.
  - If op_ready is already high on entry, the pair transfers on the first PRESENT cycle, so op_valid is high for exactly 1 cycle.
- Latency:
  - io_strb rise to io_ack high: SYNC_STAGES+1 clock edges.
  - Final strobe fall to op_valid high: SYNC_STAGES+1 edges.
- Timeout:
  - In WAIT_HI with byte_idx!=0, the counter increments every cycle with s_strb=0.
  - When the counter reaches TIMEOUT_CYCLES-1: byte_idx<=0, counter<=0, err_timeout<=1. op_a and op_b keep their partial contents but op_valid stays 0.
  - The counter is held at 0 when byte_idx==0 or in any other state.
  - err_timeout clears on the next accepted byte.
  - Timeout and strobe on the same edge: the strobe wins, the byte is captured, and no timeout occurs.
- op_a and op_b change only on byte captures; their values are don't-care while op_valid=0.
- Mid-operation reset: the frame is abandoned and all outputs return to reset values immediately (async).

Test Plan:
- Frame 00 00 04 C2 DB 0F 49 40 with op_ready=1 -> op_a=32'hC2040000 (-33.0f), op_b=32'h40490FDB (pi), op_valid high exactly 1 cycle, byte_idx back to 0.
- Check io_ack rises SYNC_STAGES+1 edges after each strobe rise and falls SYNC_STAGES+1 edges after each strobe fall.
- Backpressure: op_ready=0 for 50 cycles after frame, host drives a 9th strobe -> io_ack stays 0, op_a/op_b stable. Then op_ready=1 -> one transfer, then the 9th byte is acked and captured as byte 0 of the next frame.
- Timeout: send 3 bytes then idle TIMEOUT_CYCLES cycles -> err_timeout=1, byte_idx=0. Then a full 8-byte frame 00 00 80 3F 00 00 00 40 -> err_timeout cleared on first byte, op_a=32'h3F800000, op_b=32'h40000000.
- Strobe on the exact timeout edge (byte_idx=2) -> byte captured, byte_idx=3, err_timeout=0.
- Assert resetb low during WAIT_LO at byte 5 -> io_ack, op_valid, byte_idx go to 0 asynchronously. A fresh frame after release assembles correctly.
